slip_bus_sequencer: RTL

- Arbitrates the shared Slipstream memory bus between three requesters: DSP, blitter and CPU.
- Decodes the granted address into active-low chip selects. The decode uses the same wide NAND-style term as the macro decode gates.
- Sequences each access with region-dependent wait states, then returns an ack pulse to the owner.
- Sits between the requester address paths and the RAM/ROM/IO strobes.

---
 rtl/slip_bus_sequencer_pkg.sv | 42 ++++
 rtl/slip_bus_sequencer_if.sv | 33 +++
 rtl/slip_bus_sequencer_decode.sv | 31 +++
 rtl/slip_bus_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/slip_bus_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// slip_bus_pkg
// Shared definitions for the Slipstream bus sequencer:
//   REQ_*    requester bit positions in Req/Gnt/Ack
//   state_e  sequencer states
//   rgn_e    decoded address regions
//   ws_of()  region -> wait-state count
// ---------------------------------------------------------------------------
package slip_bus_pkg;

    localparam int REQ_CPU = 0;
    localparam int REQ_BLT = 1;
    localparam int REQ_DSP = 2;
    localparam int NUM_REQ = 3;

    // Wide enough for any sane wait-state parameter.
    localparam int WAIT_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TURN   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RGN_RAM = 2'd0,
        RGN_ROM = 2'd1,
        RGN_IO  = 2'd2
    } rgn_e;

    function automatic logic [WAIT_W-1:0] ws_of(input rgn_e rgn, input int ram_ws,
                                                 input int rom_ws, input int io_ws);
        logic [WAIT_W-1:0] ws;
        case (rgn)
            RGN_ROM: ws = WAIT_W'(rom_ws);
            RGN_IO:  ws = WAIT_W'(io_ws);
            default: ws = WAIT_W'(ram_ws);
        endcase
        return ws;
    endfunction

endpackage

// File: rtl/slip_bus_sequencer_if.sv
// ---------------------------------------------------------------------------
// slip_bus_if
// Requester/memory side of the Slipstream bus.
//   Req/Lock/Addr*          driven by the requesters (master modport)
//   Gnt/Ack/MemAddr/*CsL    driven by the sequencer  (slave modport)
//   Busy                    sequencer not idle
// ---------------------------------------------------------------------------
interface slip_bus_if #(
    parameter int ADDR_W = 20
);
    logic [2:0]        Req;
    logic              Lock;
    logic [ADDR_W-1:0] AddrCpu;
    logic [ADDR_W-1:0] AddrBlt;
    logic [ADDR_W-1:0] AddrDsp;
    logic [2:0]        Gnt;
    logic [2:0]        Ack;
    logic [ADDR_W-1:0] MemAddr;
    logic              RamCsL;
    logic              RomCsL;
    logic              IoCsL;
    logic              Busy;

    modport master (
        output Req, Lock, AddrCpu, AddrBlt, AddrDsp,
        input  Gnt, Ack, MemAddr, RamCsL, RomCsL, IoCsL, Busy
    );

    modport slave (
        input  Req, Lock, AddrCpu, AddrBlt, AddrDsp,
        output Gnt, Ack, MemAddr, RamCsL, RomCsL, IoCsL, Busy
    );
endinterface

// File: rtl/slip_bus_sequencer_decode.sv
// ---------------------------------------------------------------------------
// slip_bus_decode
// Combinational region decode of the top address nibble.
//   i_addr_hi  Addr[ADDR_W-1 -: 4]
//   o_rgn      decoded region
//   o_sel      one-hot select {io, rom, ram}, active high
// Built from the same wide NAND terms as the macro decode gates: each
// region term is a NAND of the qualifying bits, RAM is the AND of "not ROM"
// and "not IO".
// ---------------------------------------------------------------------------
module slip_bus_decode
    import slip_bus_pkg::*;
(
    input  logic [3:0] i_addr_hi,
    output rgn_e       o_rgn,
    output logic [2:0] o_sel
);
    logic w_rom_n;
    logic w_io_n;

    assign w_rom_n = ~(i_addr_hi[3] & i_addr_hi[2]);
    assign w_io_n  = ~(i_addr_hi[3] & ~i_addr_hi[2] & ~i_addr_hi[1] & ~i_addr_hi[0]);

    assign o_sel = {~w_io_n, ~w_rom_n, w_rom_n & w_io_n};

    always_comb begin
        o_rgn = RGN_RAM;
        if (!w_rom_n)     o_rgn = RGN_ROM;
        else if (!w_io_n) o_rgn = RGN_IO;
    end
endmodule

// File: rtl/slip_bus_sequencer.sv
// ---------------------------------------------------------------------------
// slip_bus_sequencer
// Arbitrates the Slipstream memory bus between DSP, blitter and CPU, drives
// the registered address and active-low chip selects, inserts region wait
// states and pulses Ack to the owner on the last access cycle.
//   MasterClock  system clock
//   nReset       asynchronous active-low reset
//   bus          slip_bus_if.slave (Req/Lock/Addr* in; Gnt/Ack/MemAddr/
//                RamCsL/RomCsL/IoCsL/Busy out)
// ---------------------------------------------------------------------------
module slip_bus_sequencer
    import slip_bus_pkg::*;
#(
    parameter int ADDR_W    = 20,
    parameter int RAM_WS    = 0,
    parameter int ROM_WS    = 2,
    parameter int IO_WS     = 1,
    parameter int MAX_DEFER = 4
)(
    input  logic     MasterClock,
    input  logic     nReset,
    slip_bus_if.slave bus
);
    localparam int DEF_W = (MAX_DEFER < 1) ? 1 : $clog2(MAX_DEFER + 1);

    state_e            r_state, w_state_nxt;
    logic [2:0]        r_gnt,   w_gnt_nxt;
    logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
    logic [2:0]        r_cs_n,  w_cs_n_nxt;     // {io, rom, ram}
    logic [WAIT_W-1:0] r_wait,  w_wait_nxt;
    logic [DEF_W-1:0]  r_defer, w_defer_nxt;

    logic              w_force;
    logic              w_last;
    logic              w_lock_go;
    logic              w_arb;
    logic [2:0]        w_win;
    logic [ADDR_W-1:0] w_win_addr;
    rgn_e              w_rgn;
    logic [2:0]        w_sel;

    // CPU has been passed over MAX_DEFER times and is still asking.
    assign w_force = (r_defer == DEF_W'(MAX_DEFER)) && bus.Req[REQ_CPU];

    // Last access cycle: Ack goes out here.
    assign w_last = (r_state == ACCESS) && (r_wait == '0);

    // Locked blitter with a request already pending re-enters ACCESS without
    // a TURN, unless the CPU starvation guard has tripped.
    assign w_lock_go = w_last && r_gnt[REQ_BLT] && bus.Lock &&
                       bus.Req[REQ_BLT] && !w_force;

    assign w_arb = ((r_state == IDLE) && (bus.Req != 3'b000)) || w_lock_go;

    always_comb begin
        w_win = 3'b000;
        if (r_state == ACCESS)        w_win[REQ_BLT] = 1'b1;  // only used by w_lock_go
        else if (w_force)             w_win[REQ_CPU] = 1'b1;
        else if (bus.Req[REQ_DSP])    w_win[REQ_DSP] = 1'b1;
        else if (bus.Req[REQ_BLT])    w_win[REQ_BLT] = 1'b1;
        else if (bus.Req[REQ_CPU])    w_win[REQ_CPU] = 1'b1;
    end

    always_comb begin
        w_win_addr = bus.AddrCpu;
        if (w_win[REQ_DSP])      w_win_addr = bus.AddrDsp;
        else if (w_win[REQ_BLT]) w_win_addr = bus.AddrBlt;
    end

    slip_bus_decode u_decode (
        .i_addr_hi (w_win_addr[ADDR_W-1 -: 4]),
        .o_rgn     (w_rgn),
        .o_sel     (w_sel)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_addr_nxt  = r_addr;
        w_cs_n_nxt  = r_cs_n;
        w_wait_nxt  = r_wait;
        w_defer_nxt = r_defer;

        if (w_arb) begin
            w_state_nxt = ACCESS;
            w_gnt_nxt   = w_win;
            w_addr_nxt  = w_win_addr;
            w_cs_n_nxt  = ~w_sel;
            w_wait_nxt  = ws_of(w_rgn, RAM_WS, ROM_WS, IO_WS);
            // Count grants that bypass a waiting CPU; saturate at the limit.
            if (w_win[REQ_CPU] || !bus.Req[REQ_CPU])
                w_defer_nxt = '0;
            else if (r_defer != DEF_W'(MAX_DEFER))
                w_defer_nxt = r_defer + 1'b1;
        end else begin
            case (r_state)
                IDLE: w_gnt_nxt = 3'b000;
                ACCESS: begin
                    if (r_wait == '0) begin
                        w_cs_n_nxt  = 3'b111;
                        w_state_nxt = TURN;
                    end else begin
                        w_wait_nxt = r_wait - 1'b1;
                    end
                end
                TURN:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge MasterClock or negedge nReset) begin
        if (!nReset) begin
            r_state <= IDLE;
            r_gnt   <= 3'b000;
            r_addr  <= '0;
            r_cs_n  <= 3'b111;
            r_wait  <= '0;
            r_defer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_addr  <= w_addr_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_wait  <= w_wait_nxt;
            r_defer <= w_defer_nxt;
        end
    end

    assign bus.Gnt     = r_gnt;
    assign bus.Ack     = w_last ? r_gnt : 3'b000;
    assign bus.MemAddr = r_addr;
    assign bus.RamCsL  = r_cs_n[0];
    assign bus.RomCsL  = r_cs_n[1];
    assign bus.IoCsL   = r_cs_n[2];
    assign bus.Busy    = (r_state != IDLE);

endmodule
